// File: rtl/snn_layer_ctrl.sv
// -----------------------------------------------------------------------------
// snn_layer_ctrl
// Time-multiplexes one binary-input MAC neuron across every neuron of a BSNN
// layer. A start pulse in IDLE latches the input spike vector. The block then
// walks the neurons in order. For each neuron it streams IN_SIZE weights from
// a sync-read weight ROM and adds the gated weights. It then adds the
// neuron's bias and compares the result against a signed threshold to form
// that neuron's output spike bit.
//
// Optional feature macro: SNN_MEMBRANE_EN
//   defined   : every neuron keeps a saturating membrane potential across
//               starts. The potential is reset to zero when the neuron fires
//               (multi-timestep LIF behaviour).
//   undefined : stateless; the potential is acc + bias on each evaluation.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   start_i      begin one layer evaluation (only honoured in IDLE)
//   in_spikes_i  binary inputs, latched when start is accepted
//   threshold_i  signed firing threshold, held stable while busy
//   w_addr_o     weight address = neuron*IN_SIZE + input
//   w_en_o       weight read enable (data returns one cycle later)
//   w_rdata_i    signed weight data
//   b_addr_o     bias address = current neuron
//   b_rdata_i    signed bias data (one-cycle read latency)
//   busy_o       high from the cycle after an accepted start through DONE
//   done_o       one-cycle pulse; spike_out_o is valid
//   spike_out_o  bit n = spike of neuron n; held until the next start
// -----------------------------------------------------------------------------
module snn_layer_ctrl #(
  parameter  int IN_SIZE  = 4,
  parameter  int OUT_SIZE = 8,
  parameter  int WIDTH    = 4,
  localparam int ACC_W    = WIDTH + $clog2(IN_SIZE + 1) + 1,
  localparam int AW       = (IN_SIZE * OUT_SIZE > 1) ? $clog2(IN_SIZE * OUT_SIZE) : 1,
  localparam int BW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [IN_SIZE-1:0]      in_spikes_i,
  input  logic signed [ACC_W-1:0] threshold_i,
  output logic [AW-1:0]           w_addr_o,
  output logic                    w_en_o,
  input  logic signed [WIDTH-1:0] w_rdata_i,
  output logic [BW-1:0]           b_addr_o,
  input  logic signed [WIDTH-1:0] b_rdata_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [OUT_SIZE-1:0]     spike_out_o
);

  localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int NW = BW;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    FIRE,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [NW-1:0]           n_q, n_d;
  logic [IW-1:0]           i_q, i_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [IN_SIZE-1:0]      in_q, in_d;
  logic [OUT_SIZE-1:0]     spike_q, spike_d;
  // Spike bit of the weight requested in the previous cycle. The weight
  // itself arrives on w_rdata_i in the current cycle.
  logic                    pend_q, pend_d;

  logic signed [ACC_W-1:0] wExt;
  logic signed [ACC_W-1:0] bExt;
  logic                    fire;

  assign wExt = {{(ACC_W - WIDTH){w_rdata_i[WIDTH-1]}}, w_rdata_i};
  assign bExt = {{(ACC_W - WIDTH){b_rdata_i[WIDTH-1]}}, b_rdata_i};

`ifdef SNN_MEMBRANE_EN
  // Two extra bits of headroom beyond the accumulator; potential saturates
  // at the membrane width instead of wrapping.
  localparam int MW = ACC_W + 2;

  logic signed [MW-1:0] mem_q [OUT_SIZE];
  logic signed [MW-1:0] memSel;
  logic signed [MW:0]   sumWide;
  logic signed [MW-1:0] potential;
  logic signed [MW-1:0] thrExt;

  localparam logic signed [MW:0] MEM_MAX = {2'b00, {(MW - 1){1'b1}}};
  localparam logic signed [MW:0] MEM_MIN = {2'b11, {(MW - 1){1'b0}}};

  assign memSel  = mem_q[n_q];
  assign sumWide = {memSel[MW-1], memSel}
                 + {{3{acc_q[ACC_W-1]}}, acc_q}
                 + {{3{bExt[ACC_W-1]}}, bExt};
  assign thrExt  = {{2{threshold_i[ACC_W-1]}}, threshold_i};

  always_comb begin
    potential = sumWide[MW-1:0];
    if (sumWide > MEM_MAX) begin
      potential = MEM_MAX[MW-1:0];
    end else if (sumWide < MEM_MIN) begin
      potential = MEM_MIN[MW-1:0];
    end
  end

  assign fire = (potential >= thrExt);

  // Membrane storage: cleared by reset only, persists across starts.
  // A neuron that fires restarts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < OUT_SIZE; k++) begin
        mem_q[k] <= '0;
      end
    end else if (state_q == FIRE) begin
      mem_q[n_q] <= fire ? '0 : potential;
    end
  end
`else
  logic signed [ACC_W-1:0] potential;

  assign potential = acc_q + bExt;
  assign fire      = (potential >= threshold_i);
`endif

  assign w_addr_o    = AW'(AW'(n_q) * AW'(IN_SIZE) + AW'(i_q));
  assign b_addr_o    = n_q;
  assign spike_out_o = spike_q;
  assign busy_o      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      i_q     <= '0;
      acc_q   <= '0;
      in_q    <= '0;
      spike_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      in_q    <= in_d;
      spike_q <= spike_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state and datapath control. The weight ROM has one cycle of read
  // latency, so every MAC/DRAIN cycle accumulates the weight requested in
  // the previous cycle (tracked by pend_q). Fetch timing is the same whatever
  // the spike pattern.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    acc_d   = acc_q;
    in_d    = in_q;
    spike_d = spike_q;
    pend_d  = 1'b0;
    w_en_o  = 1'b0;
    done_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          in_d    = in_spikes_i;
          n_d     = '0;
          i_d     = '0;
          acc_d   = '0;
          spike_d = '0;
          state_d = MAC;
        end
      end

      MAC: begin
        w_en_o = 1'b1;
        pend_d = in_q[i_q];
        if (pend_q) begin
          acc_d = acc_q + wExt;
        end
        if (i_q == IW'(IN_SIZE - 1)) begin
          state_d = DRAIN;
        end else begin
          i_d = i_q + IW'(1);
        end
      end

      DRAIN: begin
        if (pend_q) begin
          acc_d = acc_q + wExt;
        end
        state_d = FIRE;
      end

      FIRE: begin
        spike_d[n_q] = fire;
        if (n_q == NW'(OUT_SIZE - 1)) begin
          state_d = DONE;
        end else begin
          n_d     = n_q + NW'(1);
          i_d     = '0;
          acc_d   = '0;
          state_d = MAC;
        end
      end

      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
